regfile_mp: RTL and testbench

Parametrised multi-read-port integer register file for the RV32I multicycle core and its SPI debug path. It generalises the 2R/1W file to configurable width, depth and read-port count. It adds a hardwired-zero entry, optional write-to-read bypass, and a sequenced soft-clear engine with a busy/done handshake. The block sits between the decode/writeback stages and the ALU operand muxes, and its last read port is reserved for the SPI debug reader.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_clr_seq.sv | 59 +++++
 rtl/regfile_mp.sv | 66 ++++++
 tb/tb_regfile_mp.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its clear sequencer.
package regfile_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;

  function automatic int unsigned calc_aw(input int unsigned n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_clr_seq.sv
// Soft-clear sequencer: walks entries 1..NREG-1 writing zero, with busy/done handshake
// and a registered pulse for external writes discarded while not idle.
module regfile_clr_seq import regfile_pkg::*; #(
  parameter int NREG = DEF_NREG,
  parameter int AW   = calc_aw(DEF_NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr_req,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_idx,
  output logic          o_idle,
  output logic          o_clr_busy,
  output logic          o_clr_done,
  output logic          o_wr_drop
);
  clr_state_e    r_state;
  logic [AW-1:0] r_idx;

  assign o_clr_we  = (r_state == CLEAR);
  assign o_clr_idx = r_idx;
  assign o_idle    = (r_state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      o_clr_busy <= 1'b0;
      o_clr_done <= 1'b0;
      o_wr_drop  <= 1'b0;
    end else begin
      o_wr_drop <= i_we && (i_waddr != '0) && (r_state != IDLE);
      case (r_state)
        IDLE: if (i_clr_req) begin
          r_state    <= CLEAR;
          r_idx      <= AW'(1);
          o_clr_busy <= 1'b1;
        end
        CLEAR: begin
          // Storage zeroes entry r_idx on this same edge via o_clr_we.
          if (r_idx == AW'(NREG - 1)) begin
            r_state    <= DONE;
            o_clr_busy <= 1'b0;
            o_clr_done <= 1'b1;
          end else begin
            r_idx <= r_idx + AW'(1);
          end
        end
        DONE: begin
          r_state    <= IDLE;
          o_clr_done <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised NRD-read / 1-write register file, entry 0 hardwired zero, with soft clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp import regfile_pkg::*; #(
  parameter  int XLEN = DEF_XLEN,
  parameter  int NREG = DEF_NREG,
  parameter  int NRD  = 3,
  localparam int AW   = calc_aw(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done,
  output logic                wr_drop
);
  logic [XLEN-1:0] r_mem [NREG];
  logic            w_clr_we;
  logic [AW-1:0]   w_clr_idx;
  logic            w_idle;
  logic            w_wr_ok;

  assign w_wr_ok = we && (waddr != '0) && w_idle;

  regfile_clr_seq #(.NREG(NREG), .AW(AW)) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .i_clr_req (clr_req),
    .i_we      (we),
    .i_waddr   (waddr),
    .o_clr_we  (w_clr_we),
    .o_clr_idx (w_clr_idx),
    .o_idle    (w_idle),
    .o_clr_busy(clr_busy),
    .o_clr_done(clr_done),
    .o_wr_drop (wr_drop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_ok) begin
      r_mem[waddr] <= wdata;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rd;
    assign w_ra = raddr[p*AW +: AW];
    always_comb begin
      w_rd = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_ok && (w_ra == waddr)) w_rd = wdata;
`endif
      if (w_ra == '0) w_rd = '0;
    end
    assign rdata[p*XLEN +: XLEN] = w_rd;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp (default 32x32, 3 read ports).
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [14:0] raddr;
  logic [95:0] rdata;
  logic        clr_req, clr_busy, clr_done, wr_drop;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            we;
    logic [4:0]      wa;
    logic [31:0]     wd;
    logic [2:0][4:0]  ra;
    logic [2:0][31:0] exp;
  } vec_t;

  vec_t vecs [10];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd(input int p);
    return rdata[p*32 +: 32];
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] byp_val, input logic [31:0] old_val);
    return BYP ? byp_val : old_val;
  endfunction

  initial begin
    int busy_cnt, drop_cnt, drop_at;
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; clr_req = 1'b0;

    vecs[0] = '{1'b0, 5'd0,  32'h0,        {5'd31, 5'd1, 5'd0}, {32'h0, 32'h0, 32'h0}};
    vecs[1] = '{1'b1, 5'd5,  32'hDEADBEEF, {5'd3, 5'd2, 5'd0},  {32'h0, 32'h0, 32'h0}};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        {5'd0, 5'd5, 5'd5},  {32'h0, 32'hDEADBEEF, 32'hDEADBEEF}};
    vecs[3] = '{1'b1, 5'd0,  32'h12345678, {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'h0}};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'h0}};
    vecs[5] = '{1'b1, 5'd7,  32'hA5A5A5A5, {5'd5, 5'd7, 5'd0},
                {32'hDEADBEEF, pick(32'hA5A5A5A5, 32'h0), 32'h0}};
    vecs[6] = '{1'b1, 5'd7,  32'h11111111, {5'd7, 5'd7, 5'd7},
                {pick(32'h11111111, 32'hA5A5A5A5), pick(32'h11111111, 32'hA5A5A5A5),
                 pick(32'h11111111, 32'hA5A5A5A5)}};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        {5'd1, 5'd5, 5'd7},  {32'h0, 32'hDEADBEEF, 32'h11111111}};
    vecs[8] = '{1'b1, 5'd31, 32'hCAFEF00D, {5'd31, 5'd0, 5'd31},
                {pick(32'hCAFEF00D, 32'h0), 32'h0, pick(32'hCAFEF00D, 32'h0)}};
    vecs[9] = '{1'b0, 5'd0,  32'h0,        {5'd31, 5'd30, 5'd31}, {32'hCAFEF00D, 32'h0, 32'hCAFEF00D}};

    // Reset state
    #12;
    chk("rst_busy", 32'(clr_busy), 32'h0);
    chk("rst_done", 32'(clr_done), 32'h0);
    chk("rst_drop", 32'(wr_drop), 32'h0);
    for (int a = 0; a < 32; a++) begin
      raddr = {a[4:0], a[4:0], a[4:0]};
      #1;
      chk($sformatf("rst_rd%0d", a), rd(0) | rd(1) | rd(2), 32'h0);
    end
    rst = 1'b1;
    step();

    // Table-driven vectors: rdata checked before the edge, wr_drop must stay 0
    for (int v = 0; v < 10; v++) begin
      we = vecs[v].we; waddr = vecs[v].wa; wdata = vecs[v].wd; raddr = vecs[v].ra;
      #1;
      for (int p = 0; p < 3; p++)
        chk($sformatf("vec%0d_p%0d", v, p), rd(p), vecs[v].exp[p]);
      chk($sformatf("vec%0d_drop", v), 32'(wr_drop), 32'h0);
      step();
    end
    we = 1'b0;
    chk("post_vec_drop", 32'(wr_drop), 32'h0);

    // Fill r1..r31 with their index, then run a soft clear
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = i[4:0]; wdata = 32'(i);
      step();
    end
    we = 1'b0;
    raddr = {5'd12, 5'd11, 5'd10};
    #1;
    chk("fill_r10", rd(0), 32'd10);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = 0; drop_cnt = 0; drop_at = -1;
    for (int n = 0; n < 100 && clr_busy; n++) begin
      busy_cnt++;
      if (n == 10) begin
        chk("mid_clr_r10", rd(0), 32'd0);
        chk("mid_clr_r11", rd(1), 32'd11);
      end
      if (n == 4) begin
        we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF0000;
      end
      step();
      we = 1'b0;
      if (wr_drop) begin
        drop_cnt++;
        drop_at = n;
      end
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd31);
    chk("clr_done_pulse", 32'(clr_done), 32'h1);
    chk("clr_busy_low", 32'(clr_busy), 32'h0);
    chk("drop_count", 32'(drop_cnt), 32'd1);
    chk("drop_cycle", 32'(drop_at), 32'd4);
    step();
    chk("clr_done_end", 32'(clr_done), 32'h0);
    for (int a = 0; a < 32; a++) begin
      raddr = {a[4:0], a[4:0], a[4:0]};
      #1;
      chk($sformatf("clr_rd%0d", a), rd(0) | rd(1) | rd(2), 32'h0);
    end

    // Reset asserted mid-clear at idx=10
    we = 1'b1; waddr = 5'd12; wdata = 32'h12; step();
    waddr = 5'd20; wdata = 32'h20; step();
    we = 1'b0;
    raddr = {5'd4, 5'd20, 5'd12};
    #1;
    chk("pre_r20", rd(1), 32'h20);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (9) step();
    chk("at_idx10_busy", 32'(clr_busy), 32'h1);
    chk("at_idx10_r12", rd(0), 32'h12);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(clr_busy), 32'h0);
    chk("rst_mid_r12", rd(0), 32'h0);
    chk("rst_mid_r20", rd(1), 32'h0);
    #1;
    rst = 1'b1;
    step();
    we = 1'b1; waddr = 5'd4; wdata = 32'h4444;
    step();
    we = 1'b0;
    chk("post_rst_r4", rd(2), 32'h4444);
    chk("post_rst_drop", 32'(wr_drop), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
